// File: rtl/b_responder_pkg.sv
// Shared widths, AW transaction types, B response codes and FSM states for the B responder.
package b_responder_pkg;

   localparam int unsigned PID_WIDTH     = 4;
   localparam int unsigned PAWUSER_WIDTH = 2;

   localparam logic [PAWUSER_WIDTH-1:0] REGULAR = PAWUSER_WIDTH'(0);
   localparam logic [PAWUSER_WIDTH-1:0] BLOCK   = PAWUSER_WIDTH'(1);
   localparam logic [PAWUSER_WIDTH-1:0] DIVERT  = PAWUSER_WIDTH'(2);

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

   // One outstanding write; err is constant 0 unless error injection is built in.
   typedef struct packed {
      logic                     err;
      logic [PAWUSER_WIDTH-1:0] user;
      logic [PID_WIDTH-1:0]     id;
   } aw_entry_t;

   localparam int unsigned ENTRY_WIDTH = $bits(aw_entry_t);

endpackage

// File: rtl/b_responder_resp_fifo.sv
// In-order FIFO of accepted AW entries; power-of-two depth, pointers wrap naturally.
module resp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         rdata
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   // A push while full is legal only when the head leaves on the same edge.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   always_comb begin
      count_d = count;
      if (do_push && !do_pop) begin
         count_d = count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + PTR_W'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         count <= count_d;
         full  <= (count_d == CNT_W'(DEPTH));
         empty <= (count_d == '0);
      end
   end

endmodule

// File: rtl/b_responder.sv
// AXI B-channel responder: queues AW entries, returns B responses in order after a delay.
// Optional B_RESPONDER_ERR_INJECT_EN adds err_inject, turning flagged entries into SLVERR.
module b_responder
   import b_responder_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned RESP_DELAY = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [PID_WIDTH-1:0]     awid,
   input  logic [PAWUSER_WIDTH-1:0] awuser,
`ifdef B_RESPONDER_ERR_INJECT_EN
   input  logic                     err_inject,
`endif
   output logic                     bvalid,
   input  logic                     bready,
   output logic [PID_WIDTH-1:0]     bid,
   output logic [1:0]               bresp,
   input  logic                     divert_grant,
   output logic                     divert_pending,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned DLY_W = 4;

   resp_state_t      state, state_d;
   logic [DLY_W-1:0] cnt, cnt_d;
   logic [CNT_W-1:0] count;
   aw_entry_t        in_entry;
   aw_entry_t        head;
   logic             push;
   logic             pop;
   logic             load_resp;
   logic             pend_d;
   logic             divert_block;

   assign awready = ~full;
   assign push    = awvalid & awready;
   assign pop     = bvalid & bready;

   always_comb begin
      in_entry      = '0;
      in_entry.id   = awid;
      in_entry.user = awuser;
`ifdef B_RESPONDER_ERR_INJECT_EN
      in_entry.err  = err_inject;
`else
      in_entry.err  = 1'b0;
`endif
   end

   resp_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (in_entry),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .count (count),
      .rdata (head)
   );

   assign divert_block = (head.user == DIVERT) && !divert_grant;

   // Next state, delay counter and divert-pending lookahead.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      load_resp = 1'b0;
      pend_d    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_d = WAIT;
               cnt_d   = DLY_W'(RESP_DELAY);
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - DLY_W'(1);
            end else if (!divert_block) begin
               state_d   = RESP;
               load_resp = 1'b1;
            end
         end
         RESP: begin
            if (bready) begin
               if ((count > CNT_W'(1)) || push) begin
                  state_d = WAIT;
                  cnt_d   = DLY_W'(RESP_DELAY);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // After a pop the head changes, so pending is only judged from a stable head.
      pend_d = (state_d == WAIT) && (cnt_d == '0) && !pop && divert_block;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bvalid         <= 1'b0;
         bid            <= '0;
         bresp          <= BRESP_OKAY;
         divert_pending <= 1'b0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         bvalid         <= (state_d == RESP);
         divert_pending <= pend_d;
         if (load_resp) begin
            bid   <= head.id;
            bresp <= head.err ? BRESP_SLVERR : BRESP_OKAY;
         end
      end
   end

endmodule
